dmem_bus_ctrl: RTL

- Data-memory bus controller directly downstream of the MEM stage.
- Converts one MEM-stage load/store request into a handshaked transaction on the external data bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).
- Returns lane-extracted, sign/zero-extended load data.
- Holds `stall` high so the pipeline freezes until the bus acknowledges, an alignment fault is detected, or the bus times out.

---
 rtl/dmem_bus_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: turns one MEM-stage load/store into a handshaked
// external bus transaction, returns extended load data and stalls the pipeline
// until the access completes, faults or times out.
module dmem_bus_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] DAD,
    inout  wire  [31:0] DDT,
    output logic        MREQ,
    output logic        WRITE,
    output logic [1:0]  SIZE,
    input  logic        ACKD_n
);

    localparam logic [1:0]       SZ_BYTE = 2'b00;
    localparam logic [1:0]       SZ_HALF = 2'b01;
    localparam logic [1:0]       SZ_WORD = 2'b10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       addr_lo;
    logic             sgn_q;
    logic [31:0]      wdata_q;
    logic             bad_req;
    logic             timed_out;

    // Replicate store data into every lane it may land in.
    function automatic logic [31:0] place_lanes(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        case (sz)
            SZ_BYTE: r = {4{wd[7:0]}};
            SZ_HALF: r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    // Pick the addressed lane from the bus word and extend it.
    function automatic logic [31:0] extract(input logic [1:0] sz, input logic [1:0] lo,
                                            input logic sgn, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = d[{lo, 3'b000} +: 8];
        h = lo[1] ? d[31:16] : d[15:0];
        case (sz)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = d;
        endcase
        return r;
    endfunction

    // Misaligned halfword/word or reserved size never reaches the bus.
    assign bad_req = (req_size == 2'b11)
                   | ((req_size == SZ_HALF) & req_addr[0])
                   | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));

    assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);

    // Pipeline freeze covers the accept cycle and every bus-wait cycle.
    assign stall = ((state == IDLE) & req_valid) | (state == REQ);

    // Bus data is driven only during a write strobe.
    assign DDT = WRITE ? wdata_q : 32'hzzzz_zzzz;

    // Transaction FSM with registered bus and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_lo <= 2'b00;
            sgn_q   <= 1'b0;
            wdata_q <= '0;
            rdata   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            DAD     <= '0;
            MREQ    <= 1'b0;
            WRITE   <= 1'b0;
            SIZE    <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (req_valid) begin
                        addr_lo <= req_addr[1:0];
                        sgn_q   <= req_signed;
                        wdata_q <= place_lanes(req_size, req_wdata);
                        if (bad_req) begin
                            state <= ERR;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            rdata <= '0;
                        end else begin
                            state <= REQ;
                            cnt   <= '0;
                            MREQ  <= 1'b1;
                            WRITE <= req_write;
                            DAD   <= {req_addr[31:2], 2'b00};
                            SIZE  <= req_size;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + CNT_W'(1);
                    if (!ACKD_n) begin
                        state <= DONE;
                        done  <= 1'b1;
                        MREQ  <= 1'b0;
                        WRITE <= 1'b0;
                        rdata <= WRITE ? 32'h0 : extract(SIZE, addr_lo, sgn_q, DDT);
                    end else if (timed_out) begin
                        state <= ERR;
                        done  <= 1'b1;
                        err   <= 1'b1;
                        rdata <= '0;
                        MREQ  <= 1'b0;
                        WRITE <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
            endcase
        end
    end

endmodule
